// File: rtl/sbox_lut_loader_if.sv
// Config word stream into the loader and the LUT write port out of it.
// The loader connects through the slave modport; its upstream/downstream peer uses master.
interface sbox_lut_loader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 21
);
  logic              cfg_valid_i;
  logic [DATA_W-1:0] cfg_data_i;
  logic              cfg_ready_o;
  logic              upd_sbox_o;
  logic [ADDR_W-1:0] sbox_addr_o;
  logic [DATA_W-1:0] sbox_new_data_o;

  modport master (
    output cfg_valid_i, cfg_data_i,
    input  cfg_ready_o, upd_sbox_o, sbox_addr_o, sbox_new_data_o
  );

  modport slave (
    input  cfg_valid_i, cfg_data_i,
    output cfg_ready_o, upd_sbox_o, sbox_addr_o, sbox_new_data_o
  );
endinterface

// File: rtl/sbox_lut_loader.sv
// Writes a contiguous, wrapping range of S-box LUT entries from a config word stream.
// state | meaning: IDLE wait start, LOAD accept words, FLUSH last strobe, DONE pulse done.
module sbox_lut_loader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 21,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [CNT_W-1:0]  num_i,
  input  logic              abort_i,
  sbox_lut_loader_if.slave  bus,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              lut_valid_o
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  localparam logic [CNT_W-1:0] MAX_NUM = CNT_W'(2 ** ADDR_W);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              upd_q, upd_d;
  logic [ADDR_W-1:0] sbox_addr_q, sbox_addr_d;
  logic [DATA_W-1:0] sbox_data_q, sbox_data_d;
  logic              err_q, err_d;
  logic              lut_valid_q, lut_valid_d;
  logic              cfg_ready;
  logic              hs;
  logic              num_ok;

  assign cfg_ready = (state_q == LOAD) && !abort_i;
  assign hs        = bus.cfg_valid_i && cfg_ready;
  assign num_ok    = (num_i != '0) && (num_i <= MAX_NUM);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    upd_d       = 1'b0;
    sbox_addr_d = sbox_addr_q;
    sbox_data_d = sbox_data_q;
    err_d       = err_q;
    lut_valid_d = lut_valid_q;
    case (state_q)
      IDLE: begin
        // abort beats a simultaneous start, including its error side effects
        if (start_i && !abort_i) begin
          lut_valid_d = 1'b0;
          if (num_ok) begin
            state_d = LOAD;
            addr_d  = base_addr_i;
            rem_d   = num_i;
            err_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (abort_i) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (hs) begin
          upd_d       = 1'b1;
          sbox_addr_d = addr_q;
          sbox_data_d = bus.cfg_data_i;
          addr_d      = addr_q + 1'b1;
          rem_d       = rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (abort_i) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          state_d     = DONE;
          lut_valid_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      upd_q       <= 1'b0;
      sbox_addr_q <= '0;
      sbox_data_q <= '0;
      err_q       <= 1'b0;
      lut_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      upd_q       <= upd_d;
      sbox_addr_q <= sbox_addr_d;
      sbox_data_q <= sbox_data_d;
      err_q       <= err_d;
      lut_valid_q <= lut_valid_d;
    end
  end

  assign bus.cfg_ready_o     = cfg_ready;
  assign bus.upd_sbox_o      = upd_q;
  assign bus.sbox_addr_o     = sbox_addr_q;
  assign bus.sbox_new_data_o = sbox_data_q;
  assign busy_o              = (state_q != IDLE);
  assign done_o              = (state_q == DONE);
  assign err_o               = err_q;
  assign lut_valid_o         = lut_valid_q;

endmodule

// File: tb/tb_sbox_lut_loader.sv
// Randomized bench for sbox_lut_loader: a driver queues expected LUT writes, a monitor checks them.
module tb_sbox_lut_loader;
  localparam int AW = 5;
  localparam int DW = 21;
  localparam int CW = 6;
  localparam int NENT = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic [CW-1:0] num_i;
  logic          abort_i;
  logic          busy_o, done_o, err_o, lut_valid_o;

  sbox_lut_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sbox_lut_loader #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .num_i       (num_i),
    .abort_i     (abort_i),
    .bus         (bus.slave),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .lut_valid_o (lut_valid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            c;
  } exp_t;

  exp_t          exp_q[$];
  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  int            done_cnt = 0;
  logic [DW-1:0] data_tab[NENT];
  int            pat[7] = '{1, 0, 0, 1, 1, 0, 1};

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding accepted beat, one cycle later.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.upd_sbox_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("strobe_addr", 32'(bus.sbox_addr_o), 32'(e.a));
          check("strobe_data", 32'(bus.sbox_new_data_o), 32'(e.d));
          check("strobe_cycle", 32'(cyc), 32'(e.c));
        end
      end
      if (done_o) done_cnt++;
    end
  end

  task automatic issue_start(input int base, input int num);
    start_i     = 1'b1;
    base_addr_i = AW'(base);
    num_i       = CW'(num);
    @(posedge clk); #1;
    start_i     = 1'b0;
  endtask

  // vmode 0: always valid, 1: fixed gap pattern, 2: random. abort_after<0 means no abort.
  task automatic do_job(input int base, input int num, input int vmode, input int abort_after);
    int k = 0;
    int idx = 0;
    int guard = 0;
    int done0 = done_cnt;
    bit aborted = 0;
    issue_start(base, num);
    check("start_busy", 32'(busy_o), 32'd1);
    check("start_err_clr", 32'(err_o), 32'd0);
    check("start_lv_clr", 32'(lut_valid_o), 32'd0);
    while (k < num && guard < 2000) begin
      guard++;
      bus.cfg_data_i = data_tab[k];
      case (vmode)
        0:       bus.cfg_valid_i = 1'b1;
        1:       bus.cfg_valid_i = pat[idx % 7] != 0;
        default: bus.cfg_valid_i = 1'($urandom_range(0, 1));
      endcase
      idx++;
      if (abort_after >= 0 && k == abort_after) begin
        bus.cfg_valid_i = 1'b1;
        abort_i = 1'b1;
        @(negedge clk);
        check("abort_ready_low", 32'(bus.cfg_ready_o), 32'd0);
        @(posedge clk); #1;
        abort_i = 1'b0;
        bus.cfg_valid_i = 1'b0;
        aborted = 1;
        break;
      end
      @(negedge clk);
      if (bus.cfg_valid_i && bus.cfg_ready_o) begin
        exp_q.push_back('{a: AW'((base + k) % NENT), d: data_tab[k], c: cyc + 1});
        k++;
      end
      @(posedge clk); #1;
    end
    bus.cfg_valid_i = 1'b0;
    if (guard >= 2000) check("job_timeout", 32'(k), 32'(num));
    if (aborted) begin
      check("abort_busy", 32'(busy_o), 32'd0);
      check("abort_err", 32'(err_o), 32'd1);
      check("abort_lv", 32'(lut_valid_o), 32'd0);
      @(posedge clk); #1;
      check("abort_no_done", 32'(done_cnt - done0), 32'd0);
      check("abort_strobes", 32'(exp_q.size()), 32'd0);
    end else begin
      check("flush_busy", 32'(busy_o), 32'd1);
      check("flush_ready", 32'(bus.cfg_ready_o), 32'd0);
      check("flush_done", 32'(done_o), 32'd0);
      @(posedge clk); #1;
      check("done_pulse", 32'(done_o), 32'd1);
      check("done_lv", 32'(lut_valid_o), 32'd1);
      check("done_busy", 32'(busy_o), 32'd1);
      @(posedge clk); #1;
      check("post_done", 32'(done_o), 32'd0);
      check("post_busy", 32'(busy_o), 32'd0);
      check("post_lv", 32'(lut_valid_o), 32'd1);
      check("done_count", 32'(done_cnt - done0), 32'd1);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
    end
  endtask

  task automatic illegal_start(input int num);
    issue_start(3, num);
    check("illegal_err", 32'(err_o), 32'd1);
    check("illegal_busy", 32'(busy_o), 32'd0);
    check("illegal_lv", 32'(lut_valid_o), 32'd0);
    @(posedge clk); #1;
    check("illegal_idle", 32'(busy_o), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start_i = 1'b0;
    base_addr_i = '0;
    num_i = '0;
    abort_i = 1'b0;
    bus.cfg_valid_i = 1'b0;
    bus.cfg_data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_lv", 32'(lut_valid_o), 32'd0);
    check("rst_upd", 32'(bus.upd_sbox_o), 32'd0);
    check("rst_ready", 32'(bus.cfg_ready_o), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < NENT; k++) data_tab[k] = DW'(k * 3);
    do_job(0, 32, 0, -1);

    for (int k = 0; k < 4; k++) data_tab[k] = DW'(32'h1AAAA + k);
    do_job(30, 4, 0, -1);

    for (int k = 0; k < 4; k++) data_tab[k] = DW'($urandom);
    do_job(12, 4, 1, -1);

    illegal_start(0);
    illegal_start(33);
    for (int k = 0; k < 2; k++) data_tab[k] = DW'($urandom);
    do_job(7, 2, 0, -1);

    for (int k = 0; k < 8; k++) data_tab[k] = DW'($urandom);
    do_job(20, 8, 0, 5);

    // start together with abort in IDLE must be dropped entirely
    abort_i = 1'b1;
    issue_start(0, 4);
    abort_i = 1'b0;
    check("idle_abort_start_busy", 32'(busy_o), 32'd0);
    check("idle_abort_start_err", 32'(err_o), 32'd1);
    @(posedge clk); #1;

    for (int j = 0; j < 4; j++) begin
      int b = $urandom_range(0, NENT - 1);
      int n = $urandom_range(1, NENT);
      for (int k = 0; k < NENT; k++) data_tab[k] = DW'($urandom);
      do_job(b, n, 2, -1);
    end

    begin : rst_mid_job
      int k = 0;
      int guard = 0;
      for (int i = 0; i < NENT; i++) data_tab[i] = DW'($urandom);
      issue_start(5, 10);
      bus.cfg_valid_i = 1'b1;
      while (k < 3 && guard < 100) begin
        guard++;
        bus.cfg_data_i = data_tab[k];
        @(negedge clk);
        if (bus.cfg_valid_i && bus.cfg_ready_o) begin
          exp_q.push_back('{a: AW'((5 + k) % NENT), d: data_tab[k], c: cyc + 1});
          k++;
        end
        @(posedge clk); #1;
      end
      check("rst_pre_upd", 32'(bus.upd_sbox_o), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("rst_async_upd", 32'(bus.upd_sbox_o), 32'd0);
      check("rst_async_busy", 32'(busy_o), 32'd0);
      check("rst_async_ready", 32'(bus.cfg_ready_o), 32'd0);
      bus.cfg_valid_i = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      check("rst_after_lv", 32'(lut_valid_o), 32'd0);
      check("rst_after_busy", 32'(busy_o), 32'd0);
    end

    for (int k = 0; k < 3; k++) data_tab[k] = DW'($urandom);
    do_job(31, 3, 2, -1);

    repeat (3) @(posedge clk);
    #1;
    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
